// File: rtl/weight_sram_reader.sv
// Read-side master for the weight SRAM: streams LEN consecutive words from BASE onto a
// valid/ready stream, absorbing the SRAM's 1-cycle read latency with a small skid FIFO.
module weight_sram_reader #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 4096,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [3:0]        sram_wea,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  input  logic              out_ready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   base_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issue_cnt_q;
  logic [LEN_W-1:0]   recv_cnt_q;
  logic [LEN_W-1:0]   recv_next;
  logic               inflight_q;
  logic [IDX_W-1:0]   addr_q;
  logic [IDX_W-1:0]   issue_addr;
  logic               issue;
  logic               push;
  logic               pop;
  logic [OCC_W:0]     room_sum;

  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   occ_q, occ_next;

  // Only the low IDX_W address bits select a word; the rest are intentionally ignored.
  logic unused_base_hi;
  assign unused_base_hi = ^base_addr[ADDR_W-1:IDX_W];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath control: issue decision, FIFO push/pop, address generation
  // ---------------------------------------------------------------------------
  assign push       = inflight_q;
  assign pop        = (occ_q != '0) && out_ready;
  assign occ_next   = occ_q + OCC_W'(push) - OCC_W'(pop);
  assign recv_next  = recv_cnt_q + LEN_W'(pop);
  assign issue_addr = base_q + issue_cnt_q[IDX_W-1:0];

  // A read issued now lands in the FIFO two edges later, so count the one still
  // in flight and credit the slot freed by a pop happening this cycle.
  assign room_sum = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
  assign issue    = (state_q == RUN) && (issue_cnt_q != len_q) &&
                    (room_sum < (OCC_W+1)'(FIFO_DEPTH));

  assign sram_addr = {{(ADDR_W-IDX_W){1'b0}}, (issue ? issue_addr : addr_q)};
  assign sram_wea  = 4'b0000;

  assign out_valid = (occ_q != '0);
  assign out_data  = fifo_mem[rd_ptr_q];
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (issue_cnt_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish on the edge of the last handshake so done follows it directly.
        if ((recv_next == len_q) && (occ_next == '0) && !inflight_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) addr_q <= issue_addr;

      if ((state_q == IDLE) && start) begin
        base_q      <= base_addr[IDX_W-1:0];
        len_q       <= len;
        issue_cnt_q <= '0;
        recv_cnt_q  <= '0;
      end else begin
        if (issue) issue_cnt_q <= issue_cnt_q + LEN_W'(1);
        if (pop)   recv_cnt_q  <= recv_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage is only a couple of words and drives out_data directly, so
  // it is reset along with the pointers to give a defined zero output after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= sram_rdata;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_next;
    end
  end

endmodule

// File: tb/tb_weight_sram_reader.sv
// Scoreboard bench for weight_sram_reader: expected words are queued at start, a monitor
// pops and compares on every stream handshake; a simple SRAM model returns SRAM[i]=i.
module tb_weight_sram_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [12:0] len;
  logic        busy;
  logic        done;
  logic [3:0]  sram_wea;
  logic [15:0] sram_addr;
  logic [31:0] sram_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode = 0;  // 0: held high, 1: toggling, 2: held low
  logic [31:0] exp_q[$];

  weight_sram_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .sram_wea   (sram_wea),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: 1-cycle read latency, contents equal to the word address.
  always @(posedge clk) sram_rdata <= {20'd0, sram_addr[11:0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stream scoreboard, hold-under-backpressure, and constant SRAM port fields.
  logic        stall;
  logic [31:0] stall_data;
  initial begin
    stall = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        check("sram_wea_zero", {28'd0, sram_wea}, 32'd0);
        check("sram_addr_hi_zero", {28'd0, sram_addr[15:12]}, 32'd0);
        if (stall) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_data", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0d expected none (t=%0t)", out_data, $time);
          end else begin
            check("stream_data", out_data, exp_q.pop_front());
          end
        end
        stall      = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  task automatic run_start(input logic [15:0] b, input logic [12:0] l,
                           input bit accept, output int e0);
    @(negedge clk);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    if (accept)
      for (int i = 0; i < int'(l); i++) exp_q.push_back(32'((int'(b[11:0]) + i) % 4096));
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  // Returns edges from E0 to the cycle where done is seen, or -1 on timeout.
  task automatic wait_done(input int e0, input int max, output int lat);
    lat = -1;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        lat = cyc - e0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_done_end(input string name);
    @(negedge clk);
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
    check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int e0, lat, dummy;
    logic [15:0] t3_addr [4];
    t3_addr = '{16'd4094, 16'd4095, 16'd0, 16'd1};
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", {16'd0, sram_addr}, 32'd0);
    check("rst_wea", {28'd0, sram_wea}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: base=0, len=8, ready held high.
    ready_mode = 0;
    run_start(16'd0, 13'd8, 1'b1, e0);
    @(negedge clk);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(e0, 50, lat);
    check("t1_done_latency", 32'(lat), 32'd10);
    check_done_end("t1");

    // T2: base=10, len=6, ready toggling.
    ready_mode = 1;
    run_start(16'd10, 13'd6, 1'b1, e0);
    wait_done(e0, 80, lat);
    check("t2_done_seen", {31'd0, (lat >= 0)}, 32'd1);
    check_done_end("t2");
    check("t2_all_words", 32'(exp_q.size()), 32'd0);

    // T3: wrap-around from 4094.
    ready_mode = 0;
    @(negedge clk);
    run_start(16'd4094, 13'd4, 1'b1, e0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_addr", {16'd0, sram_addr}, {16'd0, t3_addr[i]});
    end
    wait_done(e0, 50, lat);
    check("t3_done_latency", 32'(lat), 32'd6);
    check_done_end("t3");

    // T4: len=0 issues nothing and goes straight to the done pulse.
    run_start(16'd500, 13'd0, 1'b1, e0);
    @(negedge clk);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_addr_held", {16'd0, sram_addr}, 32'd1);
    @(negedge clk);
    check("t4_done_width", {31'd0, done}, 32'd0);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    check("t4_no_valid", {31'd0, out_valid}, 32'd0);
    check("t4_addr_still", {16'd0, sram_addr}, 32'd1);

    // T5a: a second start mid-burst is ignored.
    run_start(16'd200, 13'd5, 1'b1, e0);
    @(negedge clk);
    run_start(16'd300, 13'd2, 1'b0, dummy);
    wait_done(e0, 50, lat);
    check("t5_done_latency", 32'(lat), 32'd7);
    check_done_end("t5");
    repeat (3) @(negedge clk);
    check("t5_no_second_burst", {31'd0, busy | out_valid}, 32'd0);
    check("t5_all_words", 32'(exp_q.size()), 32'd0);

    // T5b: asynchronous reset mid-burst with the stream stalled.
    ready_mode = 2;
    run_start(16'd50, 13'd8, 1'b1, e0);
    repeat (4) @(negedge clk);
    check("t5_stalled_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_data", out_data, 32'd0);
    check("t5_rst_addr", {16'd0, sram_addr}, 32'd0);
    exp_q.delete();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done_after_abort", {31'd0, done | busy}, 32'd0);
    end
    run_start(16'd100, 13'd3, 1'b1, e0);
    wait_done(e0, 50, lat);
    check("t5_fresh_latency", 32'(lat), 32'd5);
    check_done_end("t5_fresh");

    // T6: full-size burst at one word per cycle.
    run_start(16'd0, 13'd4096, 1'b1, e0);
    wait_done(e0, 5000, lat);
    check("t6_done_latency", 32'(lat), 32'd4098);
    check_done_end("t6");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
